i2c_bus_monitor: RTL and testbench



---
 rtl/i2c_pkg.sv | 15 +
 rtl/i2c_glitch_filter.sv | 39 +++
 rtl/i2c_bus_monitor.sv | 117 +++++++++++
 tb/tb_i2c_bus_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus front-end and protocol core:
// bus state type and default filter/timeout constants.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TOUT = 2'd2
    } i2c_bus_state_t;

    localparam int unsigned I2C_FILT_LEN       = 3;
    localparam int unsigned I2C_TIMEOUT_CYCLES = 250_000;
    localparam int unsigned I2C_CNT_W          = 24;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a persistence filter: the output only
// follows the input after FILT_LEN consecutive differing samples.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned FILT_LEN = I2C_FILT_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic [1:0] sync;
    logic [3:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            q    <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], d};
            if (sync[1] == q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                q   <= ~q;
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C pad front-end: filtered lines, SCL edge strobes, START/STOP detection,
// bus-busy/timeout state tracking and arbitration-loss detection.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int unsigned FILT_LEN       = I2C_FILT_LEN,
    parameter int unsigned TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = I2C_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    input  logic sda_o,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic timeout,
    output logic arb_lost
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic           scl_q;
    logic           sda_q;
    i2c_bus_state_t state;
    i2c_bus_state_t state_next;
    logic [CNT_W-1:0] to_cnt;
    logic [CNT_W-1:0] to_cnt_next;
    logic           restart;
    logic           lines_idle;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (scl_i),
        .q    (scl_f)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sda_i),
        .q    (sda_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    // Requiring SCL stable high across both samples suppresses START/STOP
    // when both filtered lines change in the same cycle.
    assign scl_rise  =  scl_f & ~scl_q;
    assign scl_fall  = ~scl_f &  scl_q;
    assign start_det =  scl_f &  scl_q & ~sda_f &  sda_q;
    assign stop_det  =  scl_f &  scl_q &  sda_f & ~sda_q;

    assign restart    = (state == BUSY) & start_det;
    // Both lines high now and in the previous cycle: bus released for a full cycle.
    assign lines_idle = scl_f & scl_q & sda_f & sda_q;

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_det) state_next = BUSY;
            end
            BUSY: begin
                if (stop_det)                         state_next = IDLE;
                else if (start_det)                   state_next = BUSY;
                else if (!scl_f && to_cnt == TO_LAST) state_next = TOUT;
            end
            TOUT: begin
                if (stop_det)        state_next = IDLE;
                else if (start_det)  state_next = BUSY;
                else if (lines_idle) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        to_cnt_next = to_cnt;
        if (state_next != state || restart || scl_f || state != BUSY) begin
            to_cnt_next = '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt_next = to_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            state  <= state_next;
            to_cnt <= to_cnt_next;
        end
    end

    assign bus_busy = (state == BUSY);
    assign timeout  = (state == TOUT);
    assign arb_lost = (state == BUSY) & scl_rise & sda_o & ~sda_f;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: directed scenarios plus random
// line activity compared every cycle against a sample-window reference model.
module tb_i2c_bus_monitor;

    localparam int FILT = 3;
    localparam int TO   = 100;

    localparam int O_SCLF  = 8;
    localparam int O_SDAF  = 7;
    localparam int O_RISE  = 6;
    localparam int O_FALL  = 5;
    localparam int O_START = 4;
    localparam int O_STOP  = 3;
    localparam int O_BUSY  = 2;
    localparam int O_TOUT  = 1;
    localparam int O_ARB   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_i = 1'b1;
    logic sda_i = 1'b1;
    logic sda_o = 1'b1;
    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic bus_busy, timeout, arb_lost;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_bus_monitor #(
        .FILT_LEN      (FILT),
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (24)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_o    (sda_o),
        .scl_f    (scl_f),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .bus_busy (bus_busy),
        .timeout  (timeout),
        .arb_lost (arb_lost)
    );

    assign outs = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det,
                   bus_busy, timeout, arb_lost};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A filtered line flips once its last FILT filter-input samples all
    // disagree with it; the filter input lags the pin by two clock edges.
    typedef enum int {M_IDLE, M_BUSY, M_TOUT} mstate_t;

    logic    m_scl_pins[$];
    logic    m_sda_pins[$];
    logic    m_scl_win[$];
    logic    m_sda_win[$];
    logic    m_scl_f, m_scl_q, m_sda_f, m_sda_q;
    mstate_t m_st;
    int      m_low_run;

    function automatic bit all_differ(input logic w[$], input logic f);
        foreach (w[i]) if (w[i] == f) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        m_scl_pins = '{1'b1, 1'b1};
        m_sda_pins = '{1'b1, 1'b1};
        m_scl_win.delete();
        m_sda_win.delete();
        for (int i = 0; i < FILT; i++) begin
            m_scl_win.push_back(1'b1);
            m_sda_win.push_back(1'b1);
        end
        m_scl_f = 1'b1; m_scl_q = 1'b1;
        m_sda_f = 1'b1; m_sda_q = 1'b1;
        m_st = M_IDLE;
        m_low_run = 0;
    endfunction

    function automatic void model_step(input logic scl_pin, input logic sda_pin);
        bit st, sp, held_high;
        logic s2;
        st = m_scl_f && m_scl_q && !m_sda_f && m_sda_q;
        sp = m_scl_f && m_scl_q && m_sda_f && !m_sda_q;
        held_high = m_scl_f && m_scl_q && m_sda_f && m_sda_q;
        case (m_st)
            M_IDLE: if (st) begin m_st = M_BUSY; m_low_run = 0; end
            M_BUSY: begin
                if (sp) begin
                    m_st = M_IDLE; m_low_run = 0;
                end else if (st) begin
                    m_low_run = 0;
                end else if (!m_scl_f) begin
                    m_low_run++;
                    if (m_low_run == TO) begin m_st = M_TOUT; m_low_run = 0; end
                end else begin
                    m_low_run = 0;
                end
            end
            default: begin
                if (sp)             m_st = M_IDLE;
                else if (st)        m_st = M_BUSY;
                else if (held_high) m_st = M_IDLE;
                m_low_run = 0;
            end
        endcase
        m_scl_q = m_scl_f;
        m_sda_q = m_sda_f;
        s2 = m_scl_pins.pop_front(); m_scl_pins.push_back(scl_pin);
        void'(m_scl_win.pop_front()); m_scl_win.push_back(s2);
        if (all_differ(m_scl_win, m_scl_f)) m_scl_f = ~m_scl_f;
        s2 = m_sda_pins.pop_front(); m_sda_pins.push_back(sda_pin);
        void'(m_sda_win.pop_front()); m_sda_win.push_back(s2);
        if (all_differ(m_sda_win, m_sda_f)) m_sda_f = ~m_sda_f;
    endfunction

    function automatic logic [8:0] model_outs();
        logic rise, fall, st, sp, busy;
        rise = m_scl_f & ~m_scl_q;
        fall = ~m_scl_f & m_scl_q;
        st   = m_scl_f & m_scl_q & ~m_sda_f & m_sda_q;
        sp   = m_scl_f & m_scl_q & m_sda_f & ~m_sda_q;
        busy = (m_st == M_BUSY);
        return {m_scl_f, m_sda_f, rise, fall, st, sp, busy, (m_st == M_TOUT),
                busy & rise & sda_o & ~m_sda_f};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(scl_i, sda_i);
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic tick(input logic scl, input logic sda);
        scl_i = scl;
        sda_i = sda;
        @(negedge clk);
        check("outs", 32'(outs), 32'(model_outs()));
    endtask

    task automatic hold(input logic scl, input logic sda, input int n);
        for (int i = 0; i < n; i++) tick(scl, sda);
    endtask

    task automatic run_until(input string tag, input logic scl, input logic sda,
                             input int bitpos, input logic val, input int exp_idx,
                             input int budget);
        int idx;
        idx = -1;
        for (int i = 1; i <= budget; i++) begin
            tick(scl, sda);
            if (outs[bitpos] === val) begin
                idx = i;
                break;
            end
        end
        check(tag, 32'(idx), 32'(exp_idx));
    endtask

    task automatic async_reset(input int offset);
        #(offset) rst_n = 1'b0;
        #1;
        check("rst_outs", 32'(outs), 32'(model_outs()));
        check("rst_busy", 32'(bus_busy), 32'd0);
        check("rst_sclf", 32'(scl_f), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int idx;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset_outs", 32'(outs), 32'h180);
        rst_n = 1'b1;
        hold(1, 1, 6);

        // Glitch rejection: 2-cycle low pulse on SCL never reaches scl_f.
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick((i < 2) ? 1'b0 : 1'b1, 1'b1);
            n += int'(outs[O_FALL]);
        end
        check("glitch_fall", 32'(n), 32'd0);
        check("glitch_sclf", 32'(outs[O_SCLF]), 32'd1);
        run_until("fall_latency", 0, 1, O_FALL, 1'b1, 2 + FILT, 20);
        hold(1, 1, 10);

        // START then STOP.
        sda_o = 1'b0;
        run_until("start", 1, 0, O_START, 1'b1, 2 + FILT, 20);
        check("busy_at_start", 32'(outs[O_BUSY]), 32'd0);
        tick(1, 0);
        check("busy_after_start", 32'(outs[O_BUSY]), 32'd1);
        hold(0, 0, 8);
        hold(1, 0, 8);
        run_until("stop", 1, 1, O_STOP, 1'b1, 2 + FILT, 20);
        check("busy_at_stop", 32'(outs[O_BUSY]), 32'd1);
        tick(1, 1);
        check("busy_after_stop", 32'(outs[O_BUSY]), 32'd0);
        hold(1, 1, 4);

        // Repeated START after a long low phase, then timeout and release.
        run_until("start2", 1, 0, O_START, 1'b1, 2 + FILT, 20);
        hold(0, 0, 4);
        hold(0, 1, 60);
        hold(1, 1, 8);
        run_until("rstart", 1, 0, O_START, 1'b1, 2 + FILT, 20);
        check("rstart_busy", 32'(outs[O_BUSY]), 32'd1);
        hold(1, 0, 2);
        check("rstart_still_busy", 32'(outs[O_BUSY]), 32'd1);
        run_until("tout", 0, 0, O_TOUT, 1'b1, 2 + FILT + TO, 200);
        hold(0, 0, 15);
        check("tout_held", 32'(outs[O_TOUT]), 32'd1);
        idx = -1;
        for (int i = 1; i <= 12; i++) begin
            tick(1, 1);
            if (idx < 0 && outs[O_TOUT] === 1'b0) idx = i;
        end
        check("tout_release", 32'((idx > 0) && (idx <= 10)), 32'd1);
        check("idle_after_tout", 32'(outs[2:1]), 32'd0);

        // Arbitration loss with SDA released, and none while driving low.
        run_until("start3", 1, 0, O_START, 1'b1, 2 + FILT, 20);
        hold(0, 0, 8);
        sda_o = 1'b1;
        run_until("arb", 1, 0, O_ARB, 1'b1, 2 + FILT, 20);
        check("arb_with_rise", 32'(outs[O_RISE]), 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0);
            n += int'(outs[O_ARB]);
        end
        check("arb_single", 32'(n), 32'd0);
        hold(0, 0, 8);
        sda_o = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1, 0);
            n += int'(outs[O_ARB]);
        end
        check("arb_driven_low", 32'(n), 32'd0);

        // Asynchronous reset between clock edges while busy with SCL low.
        hold(0, 0, 8);
        check("busy_before_rst", 32'(outs[O_BUSY]), 32'd1);
        scl_i = 1'b1;
        sda_i = 1'b1;
        async_reset(2);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 1);
            n += int'(outs[O_RISE] | outs[O_FALL] | outs[O_START] | outs[O_STOP] | outs[O_ARB]);
        end
        check("no_strobes_after_rst", 32'(n), 32'd0);
        check("idle_after_rst", 32'(outs[O_BUSY]), 32'd0);

        // Random line activity including glitches, long lows and resets.
        for (int it = 0; it < 1500; it++) begin
            int r;
            r = int'($urandom_range(0, 199));
            sda_o = 1'($urandom_range(0, 1));
            if (r == 0) begin
                async_reset(int'($urandom_range(1, 8)));
            end else if (r < 6) begin
                hold(0, 1'($urandom_range(0, 1)), int'($urandom_range(90, 130)));
            end else begin
                hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 8)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
